i4_mode_search: RTL

//  Intra-4x4 luma mode decision stage. Sits directly downstream of the I4 neighbour-rotation block.

---
 rtl/i4_pkg.sv | 79 +++++++
 rtl/i4_pred_gen.sv | 52 +++++
 rtl/i4_mode_search.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/i4_pkg.sv
// i4_pkg: shared mode codes, FSM states and pixel arithmetic for the intra-4x4 mode search.
package i4_pkg;
    localparam int NMODES = 10;
    localparam logic [3:0] I4_DC = 4'd0;
    localparam logic [3:0] I4_TM = 4'd1;
    localparam logic [3:0] I4_VE = 4'd2;
    localparam logic [3:0] I4_HE = 4'd3;
    localparam logic [3:0] I4_RD = 4'd4;
    localparam logic [3:0] I4_VR = 4'd5;
    localparam logic [3:0] I4_LD = 4'd6;
    localparam logic [3:0] I4_VL = 4'd7;
    localparam logic [3:0] I4_HD = 4'd8;
    localparam logic [3:0] I4_HU = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

    function automatic logic [7:0] avg3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [9:0] s;
        s = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + 10'd2;
        return s[9:2];
    endfunction

    function automatic logic [7:0] clip255(input logic signed [9:0] v);
        return v < 10'sd0 ? 8'd0 : (v > 10'sd255 ? 8'd255 : v[7:0]);
    endfunction

    function automatic logic [7:0] px_get(input logic [127:0] b, input int r, input int c);
        return b[127-32*r-8*c -: 8];
    endfunction

    function automatic logic [127:0] px_put(input logic [127:0] b, input int r, input int c, input logic [7:0] v);
        logic [127:0] o;
        o = b;
        o[127-32*r-8*c -: 8] = v;
        return o;
    endfunction

    // Edge array x: [0]=L(dup) [1..4]=L,K,J,I [5]=P [6..9]=A..D [10..13]=E..H [14,15]=H(dup).
    // Every directional pixel is avg2(x[k],x[k+1]) or avg3(x[k],x[k+1],x[k+2]); returns {is_avg2, k}.
    function automatic logic [4:0] tap(input logic [3:0] m, input int r, input int c);
        int k;
        int j;
        logic a2;
        k = 0;
        a2 = 1'b0;
        case (m)
            I4_VE: k = 5 + c;
            I4_HE: k = 3 - r;
            I4_RD: k = 4 - r + c;
            I4_VR: begin
                a2 = (r == 0) || (r == 2 && c != 0);
                k = r == 0 ? 5 + c : r == 1 ? 4 + c : r == 2 ? (c == 0 ? 3 : 4 + c) : (c == 0 ? 2 : 3 + c);
            end
            I4_LD: k = 6 + r + c;
            I4_VL: begin
                a2 = c != 3 || r < 2 ? (r % 2 == 0) : 1'b0;
                k = (r >= 2 && c == 3) ? 8 + r : 6 + (r >> 1) + c;
            end
            I4_HD: begin
                j = 2 * (3 - r) + c;
                a2 = j < 8 && j % 2 == 0;
                k = j >= 8 ? j - 3 : (j >> 1) + 1;
            end
            I4_HU: begin
                j = 2 * r + c;
                a2 = j >= 6 || j % 2 == 0;
                k = j >= 6 ? 0 : (j % 2 == 0 ? 3 - (j >> 1) : 2 - (j >> 1));
            end
            default: k = 0;
        endcase
        return {a2, k[3:0]};
    endfunction
endpackage

// File: rtl/i4_pred_gen.sv
// i4_pred_gen: combinational VP8 4x4 luma predictor for one mode from the latched neighbours.
module i4_pred_gen
    import i4_pkg::*;
(
    input  logic [3:0]   i_mode,
    input  logic [31:0]  i_left,
    input  logic [7:0]   i_top_left,
    input  logic [31:0]  i_top,
    input  logic [31:0]  i_top_right,
    output logic [127:0] o_pred
);
    logic [7:0]  w_x [16];
    logic [10:0] w_sum;
    logic [7:0]  w_dc;

    always_comb begin
        w_x[0] = i_left[7:0];
        w_x[1] = i_left[7:0];
        w_x[2] = i_left[15:8];
        w_x[3] = i_left[23:16];
        w_x[4] = i_left[31:24];
        w_x[5] = i_top_left;
        for (int i = 0; i < 4; i++) begin
            w_x[6+i]  = i_top[8*i +: 8];
            w_x[10+i] = i_top_right[8*i +: 8];
        end
        w_x[14] = i_top_right[31:24];
        w_x[15] = i_top_right[31:24];
        w_sum = 11'd4;
        for (int i = 0; i < 4; i++)
            w_sum = w_sum + {3'b000, i_top[8*i +: 8]} + {3'b000, i_left[8*i +: 8]};
        w_dc = w_sum[10:3];
    end

    always_comb begin
        o_pred = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                logic [4:0]        t;
                logic [3:0]        k;
                logic [7:0]        dir;
                logic signed [9:0] tm;
                t = tap(i_mode, r, c);
                k = t[3:0];
                dir = t[4] ? avg2(w_x[k], w_x[k+4'd1]) : avg3(w_x[k], w_x[k+4'd1], w_x[k+4'd2]);
                tm = $signed({2'b00, i_left[31-8*r -: 8]}) + $signed({2'b00, i_top[8*c +: 8]})
                   - $signed({2'b00, i_top_left});
                o_pred = px_put(o_pred, r, c, i_mode == I4_DC ? w_dc : i_mode == I4_TM ? clip255(tm) : dir);
            end
        end
    end
endmodule

// File: rtl/i4_mode_search.sv
// i4_mode_search: sequential 10-mode intra-4x4 search with a 2-stage cost pipe and valid/ready result.
// I4_SSE_EN selects sum of squared differences; otherwise the metric is SAD.
module i4_mode_search
    import i4_pkg::*;
#(
    parameter int COST_W = 21
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        i4,
    input  logic [127:0]      src,
    input  logic [31:0]       left_i,
    input  logic [7:0]        top_left_i,
    input  logic [31:0]       top_i,
    input  logic [31:0]       top_right_i,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_i4,
    output logic [3:0]        best_mode,
    output logic [COST_W-1:0] best_cost,
    output logic [127:0]      best_pred
);
`ifdef I4_SSE_EN
    localparam int TERM_W = 16;
`else
    localparam int TERM_W = 8;
`endif

    state_t              r_state, w_next;
    logic [3:0]          r_i4;
    logic [127:0]        r_src;
    logic [31:0]         r_left, r_top, r_tr;
    logic [7:0]          r_tl;
    logic [3:0]          r_cnt;
    logic                r_issue;
    logic                r_s1_vld;
    logic [3:0]          r_s1_mode;
    logic [127:0]        r_s1_pred;
    logic [TERM_W-1:0]   r_s1_term [16];
    logic [3:0]          r_best_mode;
    logic [COST_W-1:0]   r_best_cost;
    logic [127:0]        r_best_pred;
    logic [127:0]        w_pred;
    logic [TERM_W-1:0]   w_term [16];
    logic [COST_W-1:0]   w_cost;
    logic                w_start, w_issue, w_last, w_update;

    i4_pred_gen u_pred (
        .i_mode      (r_cnt),
        .i_left      (r_left),
        .i_top_left  (r_tl),
        .i_top       (r_top),
        .i_top_right (r_tr),
        .o_pred      (w_pred)
    );

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            logic [7:0] s;
            logic [7:0] p;
            logic [7:0] ad;
            s = px_get(r_src, i / 4, i % 4);
            p = px_get(w_pred, i / 4, i % 4);
            ad = s > p ? s - p : p - s;
`ifdef I4_SSE_EN
            w_term[i] = 16'(ad) * 16'(ad);
`else
            w_term[i] = ad;
`endif
        end
    end

    always_comb begin
        w_cost = '0;
        for (int i = 0; i < 16; i++)
            w_cost = w_cost + COST_W'(r_s1_term[i]);
    end

    assign w_start  = start && r_state == S_IDLE;
    assign w_issue  = r_state == S_EVAL && r_issue;
    assign w_last   = r_s1_vld && r_s1_mode == 4'(NMODES - 1);
    // Strict less-than so equal costs keep the earlier (lower-index) mode.
    assign w_update = r_s1_vld && (r_s1_mode == I4_DC || w_cost < r_best_cost);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE && start)
            w_next = S_EVAL;
        if (r_state == S_EVAL && w_last)
            w_next = S_DONE;
        if (r_state == S_DONE && out_ready)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i4        <= '0;
            r_src       <= '0;
            r_left      <= '0;
            r_tl        <= '0;
            r_top       <= '0;
            r_tr        <= '0;
            r_cnt       <= '0;
            r_issue     <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_s1_mode   <= '0;
            r_s1_pred   <= '0;
            r_s1_term   <= '{default: '0};
            r_best_mode <= '0;
            r_best_cost <= '0;
            r_best_pred <= '0;
        end else begin
            if (w_start) begin
                r_i4    <= i4;
                r_src   <= src;
                r_left  <= left_i;
                r_tl    <= top_left_i;
                r_top   <= top_i;
                r_tr    <= top_right_i;
                r_cnt   <= '0;
                r_issue <= 1'b1;
            end else if (w_issue) begin
                r_cnt   <= r_cnt + 4'd1;
                r_issue <= r_cnt != 4'(NMODES - 1);
            end
            r_s1_vld <= w_issue;
            if (w_issue) begin
                r_s1_mode <= r_cnt;
                r_s1_pred <= w_pred;
                r_s1_term <= w_term;
            end
            if (w_update) begin
                r_best_mode <= r_s1_mode;
                r_best_cost <= w_cost;
                r_best_pred <= r_s1_pred;
            end
        end
    end

    assign busy      = r_state != S_IDLE;
    assign out_valid = r_state == S_DONE;
    assign out_i4    = r_i4;
    assign best_mode = r_best_mode;
    assign best_cost = r_best_cost;
    assign best_pred = r_best_pred;
endmodule
